// File: rtl/time_manager_seq_if.sv
// time_manager_seq_if: request/step bus between analog model blocks and the time manager.
interface time_manager_seq_if #(
    parameter int n          = 4,
    parameter int width      = 32,
    parameter int time_width = 48
);
    localparam int sw = n > 1 ? $clog2(n) : 1;
    logic signed [width-1:0] dt_req [n];
    logic [n-1:0]            dt_valid;
    logic                    emu_stall;
    logic                    stop_en;
    logic [time_width-1:0]   stop_time;
    logic signed [width-1:0] emu_dt;
    logic [sw-1:0]           emu_dt_src;
    logic [time_width-1:0]   emu_time;
    logic [1:0]              state;
    logic                    time_ovf;
    modport master (
        output dt_req, dt_valid, emu_stall, stop_en, stop_time,
        input  emu_dt, emu_dt_src, emu_time, state, time_ovf
    );
    modport slave (
        input  dt_req, dt_valid, emu_stall, stop_en, stop_time,
        output emu_dt, emu_dt_src, emu_time, state, time_ovf
    );
endinterface

// File: rtl/time_manager_seq.sv
// time_manager_seq: registered min-dt arbiter with time accumulation, stall hold,
// exact-landing stop-at-time breakpoint and saturating emulation time.
module time_manager_seq #(
    parameter int     n          = 4,
    parameter int     width      = 32,
    parameter int     time_width = 48,
    parameter longint DT_MAX     = (longint'(1) << (width - 1)) - 1
) (
    input logic emu_clk,
    input logic emu_rst_n,
    time_manager_seq_if.slave bus
);
    localparam int sw = n > 1 ? $clog2(n) : 1;
    localparam logic [time_width-1:0] DT_MAX_T = time_width'(DT_MAX);
    typedef enum logic [1:0] {RUN = 2'b00, HOLD = 2'b01, STOPPED = 2'b10} state_t;
    state_t                  state_q, state_d;
    logic signed [width-1:0] emu_dt_q, emu_dt_d;
    logic [sw-1:0]           src_q, src_d;
    logic [time_width-1:0]   time_q, time_d;
    logic                    ovf_q, ovf_d;
    logic signed [width-1:0] best;
    logic [sw-1:0]           win;
    logic                    found;
    logic [time_width-1:0]   pos, step, remain, clipped;
    logic [time_width:0]     sum;
    logic [width-1:0]        applied;
    logic                    ovf, hit, release_ok;
    always_comb begin
        best  = '0;
        win   = src_q;
        found = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (bus.dt_valid[k] && (!found || bus.dt_req[k] < best)) begin
                best  = bus.dt_req[k];
                win   = sw'(k);
                found = 1'b1;
            end
        end
        pos        = best[width-1] ? '0 : time_width'($unsigned(best));
        step       = !found ? DT_MAX_T : (pos > DT_MAX_T ? DT_MAX_T : pos);
        remain     = bus.stop_time - time_q;
        clipped    = !bus.stop_en ? step :
                     (bus.stop_time > time_q ? (remain < step ? remain : step) : '0);
        sum        = {1'b0, time_q} + {1'b0, clipped};
        ovf        = sum[time_width];
        // on saturation only the distance to all-ones is applied, which is below clipped
        applied    = ovf ? width'(~time_q) : width'(clipped);
        hit        = bus.stop_en && sum >= {1'b0, bus.stop_time};
        release_ok = !bus.stop_en || bus.stop_time > time_q;
    end
    always_comb begin
        state_d  = state_q;
        emu_dt_d = '0;
        src_d    = src_q;
        time_d   = time_q;
        ovf_d    = ovf_q;
        if (bus.emu_stall) begin
            state_d = HOLD;
        end else if (state_q == STOPPED) begin
            state_d = release_ok ? RUN : STOPPED;
        end else begin
            emu_dt_d = $signed(applied);
            src_d    = win;
            time_d   = ovf ? '1 : sum[time_width-1:0];
            ovf_d    = ovf_q | ovf;
            state_d  = hit ? STOPPED : RUN;
        end
    end
    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state_q  <= RUN;
            emu_dt_q <= '0;
            src_q    <= '0;
            time_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            emu_dt_q <= emu_dt_d;
            src_q    <= src_d;
            time_q   <= time_d;
            ovf_q    <= ovf_d;
        end
    end
    assign bus.emu_dt     = emu_dt_q;
    assign bus.emu_dt_src = src_q;
    assign bus.emu_time   = time_q;
    assign bus.state      = state_q;
    assign bus.time_ovf   = ovf_q;
endmodule

// File: tb/tb_time_manager_seq.sv
// tb_time_manager_seq: directed checks of arbitration, clamps, stop, stall, saturation, reset.
module tb_time_manager_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad = 0;
    always #5 clk = ~clk;
    time_manager_seq_if #(.n(4), .width(8), .time_width(8)) bus0 ();
    time_manager_seq_if #(.n(1), .width(8), .time_width(8)) bus1 ();
    time_manager_seq #(.n(4), .width(8), .time_width(8), .DT_MAX(100)) u0 (
        .emu_clk(clk), .emu_rst_n(rst_n), .bus(bus0)
    );
    time_manager_seq #(.n(1), .width(8), .time_width(8), .DT_MAX(100)) u1 (
        .emu_clk(clk), .emu_rst_n(rst_n), .bus(bus1)
    );
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask
    task automatic set_req(input int a, input int b, input int c, input int d, input logic [3:0] v);
        bus0.dt_req[0] = 8'(a);
        bus0.dt_req[1] = 8'(b);
        bus0.dt_req[2] = 8'(c);
        bus0.dt_req[3] = 8'(d);
        bus0.dt_valid  = v;
    endtask
    task automatic chk0(input string tag, input int dt, input int src, input int t, input int st);
        chk({tag, ".dt"}, 64'(bus0.emu_dt), 64'(dt));
        chk({tag, ".src"}, 64'(bus0.emu_dt_src), 64'(src));
        chk({tag, ".time"}, 64'(bus0.emu_time), 64'(t));
        chk({tag, ".state"}, 64'(bus0.state), 64'(st));
    endtask
    initial begin
        set_req(0, 0, 0, 0, 4'b0000);
        bus0.emu_stall = 0; bus0.stop_en = 0; bus0.stop_time = 0;
        bus1.dt_req[0] = 8'd7; bus1.dt_valid = 1'b0;
        bus1.emu_stall = 0; bus1.stop_en = 0; bus1.stop_time = 0;
        #1 rst_n = 1'b0;
        #1;
        chk0("reset", 0, 0, 0, 0);
        chk("reset.ovf", 64'(bus0.time_ovf), 64'(0));
        #5 rst_n = 1'b1;
        // min selection with a tie between indices 1 and 2
        set_req(50, 20, 20, 90, 4'b1111);
        tick();
        chk0("min1", 20, 1, 20, 0);
        chk("n1_none.dt", 64'(bus1.emu_dt), 64'(100));
        chk("n1_none.src", 64'(bus1.emu_dt_src), 64'(0));
        tick(); tick();
        chk0("min3", 20, 1, 60, 0);
        set_req(50, 30, 20, 90, 4'b1111);
        tick();
        chk0("min_idx2", 20, 2, 80, 0);
        // no valid requesters: DT_MAX and src holds; negative request clamps to zero
        do_reset();
        bus1.dt_valid = 1'b1;
        set_req(50, 60, 70, 10, 4'b1111);
        tick();
        chk0("src3", 10, 3, 10, 0);
        chk("n1_valid.dt", 64'(bus1.emu_dt), 64'(7));
        chk("n1_valid.src", 64'(bus1.emu_dt_src), 64'(0));
        set_req(50, 60, 70, 10, 4'b0000);
        tick();
        chk0("none1", 100, 3, 110, 0);
        tick();
        chk0("none2", 100, 3, 210, 0);
        set_req(-5, 60, 70, 10, 4'b0001);
        tick();
        chk0("neg", 0, 0, 210, 0);
        // DT_MAX clamp then saturation of emu_time
        do_reset();
        set_req(120, 0, 0, 0, 4'b0001);
        tick();
        chk0("clamp", 100, 0, 100, 0);
        tick();
        set_req(50, 0, 0, 0, 4'b0001);
        tick();
        chk0("pre_sat", 50, 0, 250, 0);
        chk("pre_sat.ovf", 64'(bus0.time_ovf), 64'(0));
        set_req(20, 0, 0, 0, 4'b0001);
        tick();
        chk0("sat", 5, 0, 255, 0);
        chk("sat.ovf", 64'(bus0.time_ovf), 64'(1));
        tick();
        chk0("sat_hold", 0, 0, 255, 0);
        chk("sat_sticky", 64'(bus0.time_ovf), 64'(1));
        // stop-at-time with exact landing, then resume to a later breakpoint
        do_reset();
        set_req(50, 20, 20, 90, 4'b1111);
        bus0.stop_en = 1; bus0.stop_time = 45;
        tick();
        chk0("stop1", 20, 1, 20, 0);
        tick();
        chk0("stop2", 20, 1, 40, 0);
        tick();
        chk0("stop3", 5, 1, 45, 2);
        tick();
        chk0("stop4", 0, 1, 45, 2);
        bus0.stop_time = 80;
        tick();
        chk0("resume", 0, 1, 45, 0);
        tick();
        chk0("resume1", 20, 1, 65, 0);
        tick();
        chk0("resume2", 15, 1, 80, 2);
        // asynchronous reset between edges while stopped
        #1 rst_n = 1'b0;
        #1;
        chk0("async_rst", 0, 0, 0, 0);
        chk("async_rst.ovf", 64'(bus0.time_ovf), 64'(0));
        #1 rst_n = 1'b1;
        // stall for three cycles at emu_time 40
        bus0.stop_en = 0;
        tick(); tick();
        chk0("pre_stall", 20, 1, 40, 0);
        bus0.emu_stall = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk0("stall", 0, 1, 40, 1);
        end
        bus0.emu_stall = 0;
        tick();
        chk0("unstall1", 20, 1, 60, 0);
        tick();
        chk0("unstall2", 20, 1, 80, 0);
        // stall while stopped enters HOLD
        bus0.stop_en = 1; bus0.stop_time = 90;
        tick();
        chk0("stop90", 10, 1, 90, 2);
        bus0.emu_stall = 1;
        tick();
        chk0("stop_stall", 0, 1, 90, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
